// File: rtl/watch_set_ctrl.sv
// Watch time-setting controller: freezes the running time, edits hour/minute/second in turn,
// then loads the edited value back into the clock. Drives per-field blink masks for the LCD.
module watch_set_ctrl #(
   parameter int unsigned BLINK_HALF  = 25_000_000,
   parameter int unsigned TIMEOUT_CYC = 500_000_000
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       btn_mode_i,
   input  logic       btn_up_i,
   input  logic       btn_down_i,
   input  logic [7:0] cur_hour_i,
   input  logic [7:0] cur_minute_i,
   input  logic [7:0] cur_second_i,
   output logic [7:0] set_hour_o,
   output logic [7:0] set_minute_o,
   output logic [7:0] set_second_o,
   output logic       load_o,
   output logic       run_en_o,
   output logic [2:0] blink_mask_o,
   output logic [1:0] mode_o
);

   // Encoding matches the mode output directly.
   typedef enum logic [1:0] {
      StRun  = 2'd0,
      StSetH = 2'd1,
      StSetM = 2'd2,
      StSetS = 2'd3
   } state_e;

   localparam logic [31:0] BlinkLast = 32'(BLINK_HALF - 1);
   localparam logic [31:0] IdleLast  = 32'(TIMEOUT_CYC - 1);
   localparam logic [7:0]  HourMax   = 8'd23;
   localparam logic [7:0]  MinSecMax = 8'd59;

   state_e      state_q, state_d;
   logic [7:0]  hour_q, hour_d;
   logic [7:0]  minute_q, minute_d;
   logic [7:0]  second_q, second_d;
   logic        load_q, load_d;
   logic [31:0] idle_q, idle_d;
   logic [31:0] blink_q, blink_d;
   logic        phase_q, phase_d;
   logic        any_btn;
   logic        edit_ok;

   // Wrapping step; out-of-range values snap to 0 on up and to max on down.
   function automatic logic [7:0] step_field(input logic [7:0] val, input logic [7:0] max,
                                             input logic up);
      logic [7:0] res;
      if (up) begin
         res = (val >= max) ? 8'd0 : val + 8'd1;
      end else begin
         res = ((val == 8'd0) || (val > max)) ? max : val - 8'd1;
      end
      return res;
   endfunction

   // Next-state: mode sequencing, field edits, idle timeout and blink phase.
   always_comb begin
      state_d  = state_q;
      hour_d   = hour_q;
      minute_d = minute_q;
      second_d = second_q;
      load_d   = 1'b0;
      idle_d   = idle_q;
      blink_d  = blink_q;
      phase_d  = phase_q;
      any_btn  = btn_mode_i | btn_up_i | btn_down_i;
      // Up and down together cancel; mode in the same cycle overrides edits.
      edit_ok  = (state_q != StRun) && !btn_mode_i && (btn_up_i ^ btn_down_i);

      if (state_q == StRun) begin
         if (btn_mode_i) begin
            state_d  = StSetH;
            hour_d   = cur_hour_i;
            minute_d = cur_minute_i;
            second_d = cur_second_i;
         end
      end else begin
         if (btn_mode_i) begin
            case (state_q)
               StSetH:  state_d = StSetM;
               StSetM:  state_d = StSetS;
               default: begin
                  state_d = StRun;
                  load_d  = 1'b1;
               end
            endcase
         end else if (edit_ok) begin
            case (state_q)
               StSetH:  hour_d   = step_field(hour_q, HourMax, btn_up_i);
               StSetM:  minute_d = step_field(minute_q, MinSecMax, btn_up_i);
               default: second_d = step_field(second_q, MinSecMax, btn_up_i);
            endcase
         end else if (idle_q == IdleLast) begin
            // Abort without load; edited values are simply never committed.
            state_d = StRun;
         end

         idle_d = any_btn ? 32'd0 : idle_q + 32'd1;

         if (btn_mode_i || edit_ok) begin
            blink_d = 32'd0;
            phase_d = 1'b0;
         end else if (blink_q == BlinkLast) begin
            blink_d = 32'd0;
            phase_d = ~phase_q;
         end else begin
            blink_d = blink_q + 32'd1;
         end
      end

      // Counters sit at zero whenever the clock is running.
      if (state_d == StRun) begin
         idle_d  = 32'd0;
         blink_d = 32'd0;
         phase_d = 1'b0;
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= StRun;
         hour_q   <= 8'd0;
         minute_q <= 8'd0;
         second_q <= 8'd0;
         load_q   <= 1'b0;
         idle_q   <= 32'd0;
         blink_q  <= 32'd0;
         phase_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         hour_q   <= hour_d;
         minute_q <= minute_d;
         second_q <= second_d;
         load_q   <= load_d;
         idle_q   <= idle_d;
         blink_q  <= blink_d;
         phase_q  <= phase_d;
      end
   end

   // Output decode from registered state only.
   always_comb begin
      blink_mask_o = 3'b000;
      if (phase_q) begin
         case (state_q)
            StSetH:  blink_mask_o = 3'b100;
            StSetM:  blink_mask_o = 3'b010;
            StSetS:  blink_mask_o = 3'b001;
            default: blink_mask_o = 3'b000;
         endcase
      end
   end

   assign set_hour_o   = hour_q;
   assign set_minute_o = minute_q;
   assign set_second_o = second_q;
   assign load_o       = load_q;
   assign run_en_o     = (state_q == StRun);
   assign mode_o       = state_q;

endmodule

// File: tb/tb_watch_set_ctrl.sv
// Self-checking bench for watch_set_ctrl with short blink and timeout periods.
module tb_watch_set_ctrl;

   localparam int BH = 8;
   localparam int TO = 100;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       btn_mode = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
   logic [7:0] cur_h = 8'd0, cur_m = 8'd0, cur_s = 8'd0;
   logic [7:0] set_h, set_m, set_s;
   logic       load, run_en;
   logic [2:0] blink_mask;
   logic [1:0] mode;
   logic [30:0] obs;

   logic [30:0] sb[$];
   int n_run  = 0;
   int n_fail = 0;

   watch_set_ctrl #(
      .BLINK_HALF (BH),
      .TIMEOUT_CYC(TO)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .btn_mode_i  (btn_mode),
      .btn_up_i    (btn_up),
      .btn_down_i  (btn_down),
      .cur_hour_i  (cur_h),
      .cur_minute_i(cur_m),
      .cur_second_i(cur_s),
      .set_hour_o  (set_h),
      .set_minute_o(set_m),
      .set_second_o(set_s),
      .load_o      (load),
      .run_en_o    (run_en),
      .blink_mask_o(blink_mask),
      .mode_o      (mode)
   );

   always #5 clk = ~clk;

   assign obs = {mode, run_en, load, blink_mask, set_h, set_m, set_s};

   function automatic logic [30:0] pk(input logic [1:0] md, input logic rn, input logic ld,
                                      input logic [2:0] mk, input logic [7:0] h,
                                      input logic [7:0] m, input logic [7:0] s);
      return {md, rn, ld, mk, h, m, s};
   endfunction

   // Expected minute-field mask j cycles after the last blink restart.
   function automatic logic [2:0] mmask(input int j);
      return (((j / BH) % 2) == 1) ? 3'b010 : 3'b000;
   endfunction

   // Present {mode, up, down} for one edge, then sample 1 time unit later.
   task automatic drive(input logic [2:0] b);
      {btn_mode, btn_up, btn_down} = b;
      @(posedge clk);
      #1;
      {btn_mode, btn_up, btn_down} = 3'b000;
   endtask

   task automatic test_reset();
      logic [30:0] got, want;
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         sb.push_back(pk(2'd0, 1'b1, 1'b0, 3'b000, 8'd0, 8'd0, 8'd0));
         drive(3'b100);
         got  = obs;
         want = sb.pop_front();
         n_run++;
         if (got !== want) begin
            n_fail++;
            $display("FAIL reset[%0d]: got %h, expected %h", i, got, want);
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_full_cycle();
      logic [2:0]  btn[5] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b000};
      logic [30:0] ev[5];
      logic [30:0] got, want;
      ev[0] = pk(2'd1, 1'b0, 1'b0, 3'b000, 8'd10, 8'd20, 8'd30);
      ev[1] = pk(2'd2, 1'b0, 1'b0, 3'b000, 8'd10, 8'd20, 8'd30);
      ev[2] = pk(2'd3, 1'b0, 1'b0, 3'b000, 8'd10, 8'd20, 8'd30);
      ev[3] = pk(2'd0, 1'b1, 1'b1, 3'b000, 8'd10, 8'd20, 8'd30);
      ev[4] = pk(2'd0, 1'b1, 1'b0, 3'b000, 8'd10, 8'd20, 8'd30);
      {cur_h, cur_m, cur_s} = {8'd10, 8'd20, 8'd30};
      for (int i = 0; i < 5; i++) begin
         sb.push_back(ev[i]);
         drive(btn[i]);
         // The running time moves on; the captured copy must not follow it.
         {cur_h, cur_m, cur_s} = {8'd11, 8'd21, 8'd31};
         got  = obs;
         want = sb.pop_front();
         n_run++;
         if (got !== want) begin
            n_fail++;
            $display("FAIL full_cycle[%0d]: got %h, expected %h", i, got, want);
         end
      end
   endtask

   task automatic test_wrap();
      logic [2:0]  btn[8] = '{3'b100, 3'b010, 3'b100, 3'b001, 3'b100, 3'b010, 3'b100, 3'b000};
      logic [30:0] ev[8];
      logic [30:0] got, want;
      ev[0] = pk(2'd1, 1'b0, 1'b0, 3'b000, 8'd23, 8'd0, 8'd59);
      ev[1] = pk(2'd1, 1'b0, 1'b0, 3'b000, 8'd0, 8'd0, 8'd59);
      ev[2] = pk(2'd2, 1'b0, 1'b0, 3'b000, 8'd0, 8'd0, 8'd59);
      ev[3] = pk(2'd2, 1'b0, 1'b0, 3'b000, 8'd0, 8'd59, 8'd59);
      ev[4] = pk(2'd3, 1'b0, 1'b0, 3'b000, 8'd0, 8'd59, 8'd59);
      ev[5] = pk(2'd3, 1'b0, 1'b0, 3'b000, 8'd0, 8'd59, 8'd0);
      ev[6] = pk(2'd0, 1'b1, 1'b1, 3'b000, 8'd0, 8'd59, 8'd0);
      ev[7] = pk(2'd0, 1'b1, 1'b0, 3'b000, 8'd0, 8'd59, 8'd0);
      {cur_h, cur_m, cur_s} = {8'd23, 8'd0, 8'd59};
      for (int i = 0; i < 8; i++) begin
         sb.push_back(ev[i]);
         drive(btn[i]);
         got  = obs;
         want = sb.pop_front();
         n_run++;
         if (got !== want) begin
            n_fail++;
            $display("FAIL wrap[%0d]: got %h, expected %h", i, got, want);
         end
      end
   endtask

   task automatic test_simultaneous();
      logic [2:0]  btn[7] = '{3'b100, 3'b011, 3'b110, 3'b011, 3'b101, 3'b100, 3'b000};
      logic [30:0] ev[7];
      logic [30:0] got, want;
      ev[0] = pk(2'd1, 1'b0, 1'b0, 3'b000, 8'd5, 8'd6, 8'd7);
      ev[1] = pk(2'd1, 1'b0, 1'b0, 3'b000, 8'd5, 8'd6, 8'd7);
      ev[2] = pk(2'd2, 1'b0, 1'b0, 3'b000, 8'd5, 8'd6, 8'd7);
      ev[3] = pk(2'd2, 1'b0, 1'b0, 3'b000, 8'd5, 8'd6, 8'd7);
      ev[4] = pk(2'd3, 1'b0, 1'b0, 3'b000, 8'd5, 8'd6, 8'd7);
      ev[5] = pk(2'd0, 1'b1, 1'b1, 3'b000, 8'd5, 8'd6, 8'd7);
      ev[6] = pk(2'd0, 1'b1, 1'b0, 3'b000, 8'd5, 8'd6, 8'd7);
      {cur_h, cur_m, cur_s} = {8'd5, 8'd6, 8'd7};
      for (int i = 0; i < 7; i++) begin
         sb.push_back(ev[i]);
         drive(btn[i]);
         got  = obs;
         want = sb.pop_front();
         n_run++;
         if (got !== want) begin
            n_fail++;
            $display("FAIL simultaneous[%0d]: got %h, expected %h", i, got, want);
         end
      end
   endtask

   task automatic test_out_of_range();
      logic [2:0]  btn[9] = '{3'b100, 3'b010, 3'b100, 3'b001, 3'b100, 3'b001, 3'b100, 3'b010,
                              3'b001};
      logic [30:0] ev[9];
      logic [30:0] got, want;
      ev[0] = pk(2'd1, 1'b0, 1'b0, 3'b000, 8'd30, 8'd70, 8'd99);
      ev[1] = pk(2'd1, 1'b0, 1'b0, 3'b000, 8'd0, 8'd70, 8'd99);
      ev[2] = pk(2'd2, 1'b0, 1'b0, 3'b000, 8'd0, 8'd70, 8'd99);
      ev[3] = pk(2'd2, 1'b0, 1'b0, 3'b000, 8'd0, 8'd59, 8'd99);
      ev[4] = pk(2'd3, 1'b0, 1'b0, 3'b000, 8'd0, 8'd59, 8'd99);
      ev[5] = pk(2'd3, 1'b0, 1'b0, 3'b000, 8'd0, 8'd59, 8'd59);
      ev[6] = pk(2'd0, 1'b1, 1'b1, 3'b000, 8'd0, 8'd59, 8'd59);
      // Up/down in RUN are ignored.
      ev[7] = pk(2'd0, 1'b1, 1'b0, 3'b000, 8'd0, 8'd59, 8'd59);
      ev[8] = pk(2'd0, 1'b1, 1'b0, 3'b000, 8'd0, 8'd59, 8'd59);
      {cur_h, cur_m, cur_s} = {8'd30, 8'd70, 8'd99};
      for (int i = 0; i < 9; i++) begin
         sb.push_back(ev[i]);
         drive(btn[i]);
         got  = obs;
         want = sb.pop_front();
         n_run++;
         if (got !== want) begin
            n_fail++;
            $display("FAIL out_of_range[%0d]: got %h, expected %h", i, got, want);
         end
      end
   endtask

   // Enter SET_M and idle to timeout; then re-enter, press up at cycle 50, idle to timeout.
   task automatic test_timeout();
      logic [2:0]  b;
      logic [30:0] got, want, e;
      {cur_h, cur_m, cur_s} = {8'd1, 8'd2, 8'd3};
      for (int i = 0; i < 254; i++) begin
         b = 3'b000;
         if (i == 0 || i == 102) begin
            b = 3'b100;
            e = pk(2'd1, 1'b0, 1'b0, 3'b000, 8'd1, 8'd2, 8'd3);
         end else if (i == 1 || i == 103) begin
            b = 3'b100;
            e = pk(2'd2, 1'b0, 1'b0, 3'b000, 8'd1, 8'd2, 8'd3);
         end else if (i <= 101) begin
            e = (i - 1 < TO) ? pk(2'd2, 1'b0, 1'b0, mmask(i - 1), 8'd1, 8'd2, 8'd3)
                             : pk(2'd0, 1'b1, 1'b0, 3'b000, 8'd1, 8'd2, 8'd3);
         end else if (i <= 152) begin
            e = pk(2'd2, 1'b0, 1'b0, mmask(i - 103), 8'd1, 8'd2, 8'd3);
         end else if (i == 153) begin
            b = 3'b010;
            e = pk(2'd2, 1'b0, 1'b0, 3'b000, 8'd1, 8'd3, 8'd3);
         end else begin
            e = (i - 153 < TO) ? pk(2'd2, 1'b0, 1'b0, mmask(i - 153), 8'd1, 8'd3, 8'd3)
                               : pk(2'd0, 1'b1, 1'b0, 3'b000, 8'd1, 8'd3, 8'd3);
         end
         sb.push_back(e);
         drive(b);
         got  = obs;
         want = sb.pop_front();
         n_run++;
         if (got !== want) begin
            n_fail++;
            $display("FAIL timeout[%0d]: got %h, expected %h", i, got, want);
         end
      end
   endtask

   // Blink pattern in SET_M, restart on an edit, then reset mid-edit in SET_S.
   task automatic test_blink_and_reset();
      logic [2:0]  b;
      logic [30:0] got, want, e;
      {cur_h, cur_m, cur_s} = {8'd4, 8'd5, 8'd6};
      for (int i = 0; i < 44; i++) begin
         b = 3'b000;
         if (i == 0) begin
            b = 3'b100;
            e = pk(2'd1, 1'b0, 1'b0, 3'b000, 8'd4, 8'd5, 8'd6);
         end else if (i == 1) begin
            b = 3'b100;
            e = pk(2'd2, 1'b0, 1'b0, 3'b000, 8'd4, 8'd5, 8'd6);
         end else if (i <= 21) begin
            e = pk(2'd2, 1'b0, 1'b0, mmask(i - 1), 8'd4, 8'd5, 8'd6);
         end else if (i == 22) begin
            b = 3'b010;
            e = pk(2'd2, 1'b0, 1'b0, 3'b000, 8'd4, 8'd6, 8'd6);
         end else if (i <= 39) begin
            e = pk(2'd2, 1'b0, 1'b0, mmask(i - 22), 8'd4, 8'd6, 8'd6);
         end else if (i == 40) begin
            b = 3'b100;
            e = pk(2'd3, 1'b0, 1'b0, 3'b000, 8'd4, 8'd6, 8'd6);
         end else if (i == 41) begin
            b = 3'b010;
            e = pk(2'd3, 1'b0, 1'b0, 3'b000, 8'd4, 8'd6, 8'd7);
         end else begin
            // Reset on i == 42 with a commit press present; no load may follow.
            if (i == 42) begin
               rst = 1'b1;
               b   = 3'b100;
            end
            e = pk(2'd0, 1'b1, 1'b0, 3'b000, 8'd0, 8'd0, 8'd0);
         end
         sb.push_back(e);
         drive(b);
         rst  = 1'b0;
         got  = obs;
         want = sb.pop_front();
         n_run++;
         if (got !== want) begin
            n_fail++;
            $display("FAIL blink_reset[%0d]: got %h, expected %h", i, got, want);
         end
      end
   endtask

   initial begin
      test_reset();
      test_full_cycle();
      test_wrap();
      test_simultaneous();
      test_out_of_range();
      test_timeout();
      test_blink_and_reset();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
